uart_rx_param: RTL and testbench

//  Parametrised UART receiver: successor of the 8N1 tick-clocked receiver.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_param.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   rx_state_e  : receiver FSM states (3-bit encoding)
//   PAR_MODE_*  : parity-mode constants for the PARITY_ODD parameter
//   majority3() : 2-of-3 vote used for bit sampling
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } rx_state_e;

  localparam int PAR_MODE_EVEN = 0;
  localparam int PAR_MODE_ODD  = 1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Synchroniser for the asynchronous serial line.
//   clk   : system clock
//   reset : async active-low reset; chain resets to 1 (idle line)
//   d     : asynchronous input
//   q     : synchronised output, STAGES clocks of latency
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '1;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver, system-clocked with the baud tick as enable.
//   clk, reset      : system clock, async active-low reset
//   tick            : NUM_TICKS x baud enable pulse
//   rx_bit          : asynchronous serial input, idle high
//   rx_done_tick    : 1-clk pulse when a frame completes
//   data_out        : last received word (held)
//   parity_err      : parity mismatch in last frame (held)
//   frame_err       : a stop bit sampled 0 in last frame (held)
//   break_det       : last frame was an all-zero break (held)
//   busy            : FSM not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int NBIT_DATA   = 8,
  parameter int NUM_TICKS   = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = PAR_MODE_EVEN,
  parameter int NUM_STOP    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx_bit,
  output logic                 rx_done_tick,
  output logic [NBIT_DATA-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int TW = $clog2(NUM_TICKS);
  localparam int BW = $clog2(NBIT_DATA + 1);
  localparam logic [TW-1:0] T_MID  = TW'(NUM_TICKS/2 - 1);
  localparam logic [TW-1:0] T_S0   = TW'(NUM_TICKS - 3);
  localparam logic [TW-1:0] T_S1   = TW'(NUM_TICKS - 2);
  localparam logic [TW-1:0] T_LAST = TW'(NUM_TICKS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBIT_DATA - 1);
  localparam logic          STOP_LAST = 1'(NUM_STOP - 1);

  rx_state_e state, state_nxt;
  logic                 rxs;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic [BW-1:0]        bcnt, bcnt_nxt;
  logic [NBIT_DATA-1:0] buffer, buf_nxt;
  logic [1:0]           samp, samp_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 perr, perr_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic                 s_ones, s_ones_nxt;   // every stop bit so far was 1
  logic                 s_zero, s_zero_nxt;   // every stop bit so far was 0
  logic                 bit_val, done, brk, ones, zeros;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_bit),
    .q     (rxs)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    tcnt_nxt     = tcnt;
    bcnt_nxt     = bcnt;
    buf_nxt      = buffer;
    samp_nxt     = samp;
    par_bit_nxt  = par_bit;
    perr_nxt     = perr;
    stop_idx_nxt = stop_idx;
    s_ones_nxt   = s_ones;
    s_zero_nxt   = s_zero;
    done         = 1'b0;
    brk          = 1'b0;
    // third vote is the live sample at the terminal count
    bit_val      = majority3(samp[1], samp[0], rxs);
    ones         = s_ones & bit_val;
    zeros        = s_zero & ~bit_val;
    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            state_nxt   = S_START;
            tcnt_nxt    = '0;
            perr_nxt    = 1'b0;
            par_bit_nxt = 1'b0;
          end
        end
        S_START: begin
          if (tcnt == T_MID) begin
            if (rxs) state_nxt = S_IDLE;
            else begin
              state_nxt = S_DATA;
              tcnt_nxt  = '0;
              bcnt_nxt  = '0;
            end
          end else tcnt_nxt = tcnt + 1'b1;
        end
        S_DATA, S_PARITY, S_STOP: begin
          if (tcnt == T_S0) samp_nxt[0] = rxs;
          if (tcnt == T_S1) samp_nxt[1] = rxs;
          if (tcnt == T_LAST) begin
            tcnt_nxt = '0;
            if (state == S_DATA) begin
              buf_nxt = {bit_val, buffer[NBIT_DATA-1:1]};
              if (bcnt == B_LAST) begin
                bcnt_nxt     = '0;
                state_nxt    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                stop_idx_nxt = 1'b0;
                s_ones_nxt   = 1'b1;
                s_zero_nxt   = 1'b1;
              end else bcnt_nxt = bcnt + 1'b1;
            end else if (state == S_PARITY) begin
              par_bit_nxt = bit_val;
              perr_nxt    = (^buffer) ^ bit_val ^ (PARITY_ODD != 0);
              state_nxt   = S_STOP;
            end else begin
              s_ones_nxt = ones;
              s_zero_nxt = zeros;
              if (stop_idx == STOP_LAST) begin
                done      = 1'b1;
                brk       = (buffer == '0) && ((PARITY_EN == 0) || !par_bit) && zeros;
                state_nxt = brk ? S_BRK_WAIT : S_IDLE;
              end else stop_idx_nxt = stop_idx + 1'b1;
            end
          end else tcnt_nxt = tcnt + 1'b1;
        end
        S_BRK_WAIT: if (rxs) state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt         <= '0;
      bcnt         <= '0;
      buffer       <= '0;
      samp         <= '0;
      par_bit      <= 1'b0;
      perr         <= 1'b0;
      stop_idx     <= 1'b0;
      s_ones       <= 1'b1;
      s_zero       <= 1'b1;
      rx_done_tick <= 1'b0;
      data_out     <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      tcnt         <= tcnt_nxt;
      bcnt         <= bcnt_nxt;
      buffer       <= buf_nxt;
      samp         <= samp_nxt;
      par_bit      <= par_bit_nxt;
      perr         <= perr_nxt;
      stop_idx     <= stop_idx_nxt;
      s_ones       <= s_ones_nxt;
      s_zero       <= s_zero_nxt;
      rx_done_tick <= done;
      if (done) begin
        data_out   <= buffer;
        parity_err <= perr;
        frame_err  <= ~ones;
        break_det  <= brk;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 8N2) each on
// its own line; tick every 4 clk, 64 clk per bit.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic line = 1'b1;
  int   sel = 0;
  logic rx0, rx1, rx2;
  assign rx0 = (sel == 0) ? line : 1'b1;
  assign rx1 = (sel == 1) ? line : 1'b1;
  assign rx2 = (sel == 2) ? line : 1'b1;

  logic       done0, done1, done2;
  logic [7:0] d0, d1, d2;
  logic       pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, by0, by1, by2;

  int  checks = 0;
  int  failures = 0;
  int  cnt0 = 0, cnt1 = 0, cnt2 = 0;
  time t_done0 = 0, t_start = 0;

  uart_rx_param dut0 (
    .clk(clk), .reset(rst_n), .tick(tick), .rx_bit(rx0), .rx_done_tick(done0),
    .data_out(d0), .parity_err(pe0), .frame_err(fe0), .break_det(bk0), .busy(by0));

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(rst_n), .tick(tick), .rx_bit(rx1), .rx_done_tick(done1),
    .data_out(d1), .parity_err(pe1), .frame_err(fe1), .break_det(bk1), .busy(by1));

  uart_rx_param #(.NUM_STOP(2)) dut2 (
    .clk(clk), .reset(rst_n), .tick(tick), .rx_bit(rx2), .rx_done_tick(done2),
    .data_out(d2), .parity_err(pe2), .frame_err(fe2), .break_det(bk2), .busy(by2));

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  end

  always @(negedge clk) begin
    if (done0 === 1'b1) begin cnt0++; t_done0 = $time; end
    if (done1 === 1'b1) cnt1++;
    if (done2 === 1'b1) cnt2++;
  end

  // Drives a full frame; a 0 stop bit is held low only past the centre so the
  // trailing low half-bit cannot launch a real frame. bnc >= 0 inverts that
  // data bit for one clk near its centre.
  task automatic send_frame(input int s, input logic [7:0] d, input bit pen, input bit pbit,
                            input int nstop, input bit st0, input bit st1, input int bnc);
    logic q[$];
    int   nst;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) q.push_back(pbit);
    nst = q.size();
    q.push_back(st0);
    if (nstop == 2) q.push_back(st1);
    sel = s;
    @(negedge clk);
    t_start = $time;
    for (int k = 0; k < q.size(); k++) begin
      line = q[k];
      if (k >= nst && q[k] == 1'b0) begin
        repeat (44) @(negedge clk);
        line = 1'b1;
        repeat (20) @(negedge clk);
      end else if (bnc >= 0 && k == bnc + 1) begin
        repeat (34) @(negedge clk);
        line = ~q[k];
        @(negedge clk);
        line = q[k];
        repeat (29) @(negedge clk);
      end else repeat (64) @(negedge clk);
    end
    line = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++; if ({done0, d0, pe0, fe0, bk0, by0} !== 13'd0) begin
      failures++; $display("FAIL reset_dut0 got %h want 0", {done0, d0, pe0, fe0, bk0, by0}); end
    checks++; if ({by1, by2, d1, d2} !== 18'd0) begin
      failures++; $display("FAIL reset_dut12 got %h want 0", {by1, by2, d1, d2}); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if ({cnt0, cnt1, cnt2} !== 96'd0) begin
      failures++; $display("FAIL reset_no_pulse got %0d/%0d/%0d want 0", cnt0, cnt1, cnt2); end
  endtask

  task automatic test_8n1();
    int c; time lat;
    c = cnt0;
    send_frame(0, 8'hA5, 0, 0, 1, 1, 1, -1);
    checks++; if (cnt0 - c !== 1) begin
      failures++; $display("FAIL 8n1_pulses got %0d want 1", cnt0 - c); end
    checks++; if (d0 !== 8'hA5) begin
      failures++; $display("FAIL 8n1_data got %h want a5", d0); end
    checks++; if ({pe0, fe0, bk0} !== 3'b000) begin
      failures++; $display("FAIL 8n1_flags got %b want 000", {pe0, fe0, bk0}); end
    lat = (t_done0 - t_start) / 10;
    checks++; if (lat < 606 || lat > 620) begin
      failures++; $display("FAIL 8n1_latency got %0d clk want 606..620", lat); end
  endtask

  task automatic test_glitch();
    int c;
    c = cnt0; sel = 0;
    @(negedge clk); line = 1'b0;
    repeat (24) @(negedge clk); line = 1'b1;
    checks++; if (by0 !== 1'b1) begin
      failures++; $display("FAIL glitch_busy_high got %b want 1", by0); end
    repeat (100) @(negedge clk);
    checks++; if (by0 !== 1'b0) begin
      failures++; $display("FAIL glitch_busy_drop got %b want 0", by0); end
    checks++; if (cnt0 - c !== 0) begin
      failures++; $display("FAIL glitch_pulses got %0d want 0", cnt0 - c); end
  endtask

  task automatic test_parity();
    int c;
    c = cnt1;
    send_frame(1, 8'h3C, 1, 1, 1, 1, 1, -1);
    checks++; if (cnt1 - c !== 1) begin
      failures++; $display("FAIL par_bad_pulses got %0d want 1", cnt1 - c); end
    checks++; if ({d1, pe1, fe1} !== {8'h3C, 1'b1, 1'b0}) begin
      failures++; $display("FAIL par_bad got d=%h pe=%b fe=%b want 3c 1 0", d1, pe1, fe1); end
    send_frame(1, 8'h07, 1, 1, 1, 1, 1, -1);
    checks++; if ({d1, pe1, fe1, bk1} !== {8'h07, 3'b000}) begin
      failures++; $display("FAIL par_good got d=%h pe=%b fe=%b bk=%b want 07 0 0 0", d1, pe1, fe1, bk1); end
  endtask

  task automatic test_frame_err();
    int c;
    c = cnt0;
    send_frame(0, 8'h55, 0, 0, 1, 0, 1, -1);
    repeat (64) @(negedge clk);
    checks++; if (cnt0 - c !== 1) begin
      failures++; $display("FAIL fe_pulses got %0d want 1", cnt0 - c); end
    checks++; if ({d0, fe0, bk0, pe0} !== {8'h55, 3'b100}) begin
      failures++; $display("FAIL fe_1stop got d=%h fe=%b bk=%b pe=%b want 55 1 0 0", d0, fe0, bk0, pe0); end
    c = cnt2;
    send_frame(2, 8'h3A, 0, 0, 2, 1, 1, -1);
    checks++; if ({d2, fe2} !== {8'h3A, 1'b0}) begin
      failures++; $display("FAIL fe_2stop_clean got d=%h fe=%b want 3a 0", d2, fe2); end
    send_frame(2, 8'hC3, 0, 0, 2, 1, 0, -1);
    repeat (64) @(negedge clk);
    checks++; if (cnt2 - c !== 2) begin
      failures++; $display("FAIL fe_2stop_pulses got %0d want 2", cnt2 - c); end
    checks++; if ({d2, fe2, bk2} !== {8'hC3, 2'b10}) begin
      failures++; $display("FAIL fe_2stop got d=%h fe=%b bk=%b want c3 1 0", d2, fe2, bk2); end
  endtask

  task automatic test_break();
    int c;
    c = cnt0; sel = 0;
    @(negedge clk); line = 1'b0;
    repeat (1280) @(negedge clk);
    checks++; if (cnt0 - c !== 1) begin
      failures++; $display("FAIL brk_pulses got %0d want 1", cnt0 - c); end
    checks++; if ({d0, fe0, bk0} !== {8'h00, 2'b11}) begin
      failures++; $display("FAIL brk_flags got d=%h fe=%b bk=%b want 00 1 1", d0, fe0, bk0); end
    checks++; if (by0 !== 1'b1) begin
      failures++; $display("FAIL brk_busy got %b want 1", by0); end
    line = 1'b1;
    repeat (128) @(negedge clk);
    checks++; if (by0 !== 1'b0 || cnt0 - c !== 1) begin
      failures++; $display("FAIL brk_release got busy=%b pulses=%0d want 0 1", by0, cnt0 - c); end
    send_frame(0, 8'h81, 0, 0, 1, 1, 1, -1);
    checks++; if ({d0, pe0, fe0, bk0} !== {8'h81, 3'b000}) begin
      failures++; $display("FAIL brk_after got d=%h pe=%b fe=%b bk=%b want 81 0 0 0", d0, pe0, fe0, bk0); end
  endtask

  task automatic test_reset_midframe();
    int c;
    c = cnt0; sel = 0;
    @(negedge clk); line = 1'b0;
    repeat (352) @(negedge clk);
    rst_n = 1'b0; line = 1'b1;
    @(negedge clk);
    checks++; if ({d0, fe0, bk0, pe0, by0, done0} !== 13'd0) begin
      failures++; $display("FAIL midrst_outputs got %h want 0", {d0, fe0, bk0, pe0, by0, done0}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (192) @(negedge clk);
    checks++; if (cnt0 - c !== 0 || by0 !== 1'b0) begin
      failures++; $display("FAIL midrst_idle got pulses=%0d busy=%b want 0 0", cnt0 - c, by0); end
    send_frame(0, 8'h12, 0, 0, 1, 1, 1, 1);
    checks++; if (cnt0 - c !== 1) begin
      failures++; $display("FAIL bounce_pulses got %0d want 1", cnt0 - c); end
    checks++; if ({d0, pe0, fe0, bk0} !== {8'h12, 3'b000}) begin
      failures++; $display("FAIL bounce_data got d=%h flags=%b want 12 000", d0, {pe0, fe0, bk0}); end
    send_frame(0, 8'h12, 0, 0, 1, 1, 1, 4);
    checks++; if (d0 !== 8'h12 || cnt0 - c !== 2) begin
      failures++; $display("FAIL bounce_zero got d=%h pulses=%0d want 12 2", d0, cnt0 - c); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_glitch();
    test_parity();
    test_frame_err();
    test_break();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
